cond_check_unit: RTL and testbench

//  Parametrised successor to the single-bank EQ/NE condition checker.
//  - Evaluates all 16 ARM condition codes against NZCV flags.
//  - Holds NUM_CTX independent flag banks, each with a shadow copy for save/restore on exception entry/return.
//  - Sits in the decode/execute boundary of the pipeline.
//  - Gates register/flag/PC writes of the current instruction via cond_ex_o.

---
 rtl/cond_pkg.sv | 30 +++
 rtl/cond_eval.sv | 41 ++++
 rtl/cond_check_unit.sv | 106 ++++++++++
 tb/tb_cond_check_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared constants for the condition-check unit:
// ARM condition codes, NZCV flag indices and flag-write select bits.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_eval.sv
// Pure combinational ARM condition evaluator (shared with branch predictor).
// Ports: i_cond[3:0] condition field, i_nzcv[3:0] flags, o_pass result.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_nzcv,
  output logic       o_pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_nzcv[FLAG_N];
  assign w_z = i_nzcv[FLAG_Z];
  assign w_c = i_nzcv[FLAG_C];
  assign w_v = i_nzcv[FLAG_V];

  always_comb begin
    o_pass = 1'b0;
    unique case (i_cond)
      COND_EQ: o_pass = w_z;
      COND_NE: o_pass = !w_z;
      COND_CS: o_pass = w_c;
      COND_CC: o_pass = !w_c;
      COND_MI: o_pass = w_n;
      COND_PL: o_pass = !w_n;
      COND_VS: o_pass = w_v;
      COND_VC: o_pass = !w_v;
      COND_HI: o_pass = w_c && !w_z;
      COND_LS: o_pass = !w_c || w_z;
      COND_GE: o_pass = (w_n == w_v);
      COND_LT: o_pass = (w_n != w_v);
      COND_GT: o_pass = !w_z && (w_n == w_v);
      COND_LE: o_pass = w_z || (w_n != w_v);
      COND_AL: o_pass = 1'b1;
      COND_NV: o_pass = 1'b1; // legacy NV encoding behaves as AL
      default: o_pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_check_unit.sv
// Multi-context NZCV flag banks with shadow save/restore and ARM condition gating.
// Ports: clk, reset (sync, high), valid_i, ctx_i, cond_i, flag_w_i, alu_flags_i,
//   save_i, restore_i -> cond_ex_o, flags_o; exec_cnt_o/squash_cnt_o with COND_STATS_EN.
module cond_check_unit
  import cond_pkg::*;
#(
  parameter int NUM_CTX = 2,
`ifdef COND_STATS_EN
  parameter int CNT_W   = 16,
`endif
  parameter int CTX_W   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [CTX_W-1:0] ctx_i,
  input  logic [3:0]       cond_i,
  input  logic [1:0]       flag_w_i,
  input  logic [3:0]       alu_flags_i,
  input  logic             save_i,
  input  logic             restore_i,
  output logic             cond_ex_o,
`ifdef COND_STATS_EN
  output logic [CNT_W-1:0] exec_cnt_o,
  output logic [CNT_W-1:0] squash_cnt_o,
`endif
  output logic [3:0]       flags_o
);

  logic [3:0]  r_live   [NUM_CTX];
  logic [3:0]  r_shadow [NUM_CTX];

  logic [31:0] w_ctx;
  logic        w_in_rng;
  logic        w_ok;
  logic        w_pass;
  logic        w_wr;
  logic [3:0]  w_cur;

  assign w_ctx    = 32'(ctx_i);
  assign w_in_rng = (w_ctx < 32'(NUM_CTX));
  assign w_ok     = valid_i && w_in_rng;

  // Mux rather than direct index so out-of-range ctx reads as zero.
  always_comb begin
    w_cur = 4'b0000;
    for (int i = 0; i < NUM_CTX; i++) begin
      if (w_ctx == 32'(i)) w_cur = r_live[i];
    end
  end

  cond_eval u_eval (
    .i_cond (cond_i),
    .i_nzcv (w_cur),
    .o_pass (w_pass)
  );

  assign w_wr      = w_ok && w_pass;
  assign cond_ex_o = w_wr;
  assign flags_o   = w_cur;

  // All branches read pre-edge values; restore beats ALU write,
  // save+restore swaps, save+write stores the old live flags.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CTX; i++) begin
      if (reset) begin
        r_live[i]   <= 4'b0000;
        r_shadow[i] <= 4'b0000;
      end else if (w_in_rng && (w_ctx == 32'(i))) begin
        if (save_i && restore_i) begin
          r_live[i]   <= r_shadow[i];
          r_shadow[i] <= r_live[i];
        end else if (restore_i) begin
          r_live[i] <= r_shadow[i];
        end else begin
          if (save_i) r_shadow[i] <= r_live[i];
          if (w_wr && flag_w_i[FLAGW_NZ])
            r_live[i][FLAG_N:FLAG_Z] <= alu_flags_i[FLAG_N:FLAG_Z];
          if (w_wr && flag_w_i[FLAGW_CV])
            r_live[i][FLAG_C:FLAG_V] <= alu_flags_i[FLAG_C:FLAG_V];
        end
      end
    end
  end

`ifdef COND_STATS_EN
  logic [CNT_W-1:0] r_exec;
  logic [CNT_W-1:0] r_squash;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_exec   <= '0;
      r_squash <= '0;
    end else begin
      if (w_ok && w_pass && (r_exec != '1))
        r_exec <= r_exec + 1'b1;
      if (w_ok && !w_pass && (r_squash != '1))
        r_squash <= r_squash + 1'b1;
    end
  end

  assign exec_cnt_o   = r_exec;
  assign squash_cnt_o = r_squash;
`endif

endmodule

// File: tb/tb_cond_check_unit.sv
// Directed self-checking bench for cond_check_unit.
// Two contexts, 2-bit ctx so the out-of-range index is reachable.
module tb_cond_check_unit;
  import cond_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_i;
  logic [1:0] ctx_i;
  logic [3:0] cond_i;
  logic [1:0] flag_w_i;
  logic [3:0] alu_flags_i;
  logic       save_i;
  logic       restore_i;
  logic       cond_ex_o;
  logic [3:0] flags_o;
`ifdef COND_STATS_EN
  logic [3:0] exec_cnt_o;
  logic [3:0] squash_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cond_check_unit #(
    .NUM_CTX (2),
`ifdef COND_STATS_EN
    .CNT_W   (4),
`endif
    .CTX_W   (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_i      (valid_i),
    .ctx_i        (ctx_i),
    .cond_i       (cond_i),
    .flag_w_i     (flag_w_i),
    .alu_flags_i  (alu_flags_i),
    .save_i       (save_i),
    .restore_i    (restore_i),
    .cond_ex_o    (cond_ex_o),
`ifdef COND_STATS_EN
    .exec_cnt_o   (exec_cnt_o),
    .squash_cnt_o (squash_cnt_o),
`endif
    .flags_o      (flags_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_i = 1'b0; ctx_i = 2'd0; cond_i = COND_AL;
    flag_w_i = 2'b00; alu_flags_i = 4'h0;
    save_i = 1'b0; restore_i = 1'b0;
  endtask

  task automatic drive(input logic [1:0] c, input logic [3:0] cnd,
                       input logic [1:0] fw, input logic [3:0] alu,
                       input logic sv, input logic rs);
    valid_i = 1'b1; ctx_i = c; cond_i = cnd;
    flag_w_i = fw; alu_flags_i = alu;
    save_i = sv; restore_i = rs;
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    drive(2'd0, COND_EQ, 2'b00, 4'h0, 1'b0, 1'b0);
    checks++;
    if (cond_ex_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_eq got %b want 0", cond_ex_o);
    end
    drive(2'd0, COND_NE, 2'b00, 4'h0, 1'b0, 1'b0);
    checks++;
    if (cond_ex_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ne got %b want 1", cond_ex_o);
    end
    checks++;
    if (flags_o !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags0 got %b want 0000", flags_o);
    end
    drive(2'd1, COND_NE, 2'b00, 4'h0, 1'b0, 1'b0);
    checks++;
    if (flags_o !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags1 got %b want 0000", flags_o);
    end
    idle();
    step();
  endtask

  task automatic test_write_eval();
    logic [3:0] conds [6];
    logic       exp   [6];
    conds = '{COND_EQ, COND_CS, COND_HI, COND_LS, COND_GE, COND_GT};
    exp   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    drive(2'd0, COND_AL, 2'b11, 4'b0110, 1'b0, 1'b0);
    // write not visible in the same cycle
    checks++;
    if (flags_o !== 4'b0000) begin
      errors++;
      $display("FAIL no_bypass got %b want 0000", flags_o);
    end
    step();
    idle();
    #1;
    checks++;
    if (flags_o !== 4'b0110) begin
      errors++;
      $display("FAIL write_flags got %b want 0110", flags_o);
    end
    for (int i = 0; i < 6; i++) begin
      drive(2'd0, conds[i], 2'b11, 4'hF, 1'b0, 1'b0);
      checks++;
      if (cond_ex_o !== exp[i]) begin
        errors++;
        $display("FAIL eval_cond%0h got %b want %b", conds[i], cond_ex_o, exp[i]);
      end
    end
    idle();
    #1;
  endtask

  task automatic test_squash();
    drive(2'd0, COND_NE, 2'b11, 4'b1001, 1'b0, 1'b0);
    checks++;
    if (cond_ex_o !== 1'b0) begin
      errors++;
      $display("FAIL squash_ex got %b want 0", cond_ex_o);
    end
    step();
    drive(2'd0, COND_AL, 2'b00, 4'h0, 1'b0, 1'b0);
    checks++;
    if (flags_o !== 4'b0110) begin
      errors++;
      $display("FAIL squash_keep got %b want 0110", flags_o);
    end
    drive(2'd1, COND_NE, 2'b11, 4'b1001, 1'b0, 1'b0);
    step();
    drive(2'd1, COND_AL, 2'b00, 4'h0, 1'b0, 1'b0);
    checks++;
    if (flags_o !== 4'b1001) begin
      errors++;
      $display("FAIL ctx1_write got %b want 1001", flags_o);
    end
    // CV-only update keeps NZ
    drive(2'd1, COND_AL, 2'b01, 4'b0110, 1'b0, 1'b0);
    step();
    drive(2'd1, COND_AL, 2'b00, 4'h0, 1'b0, 1'b0);
    checks++;
    if (flags_o !== 4'b1010) begin
      errors++;
      $display("FAIL partial_cv got %b want 1010", flags_o);
    end
    drive(2'd0, COND_AL, 2'b00, 4'h0, 1'b0, 1'b0);
    checks++;
    if (flags_o !== 4'b0110) begin
      errors++;
      $display("FAIL ctx0_isolated got %b want 0110", flags_o);
    end
    idle();
  endtask

  task automatic test_save_restore();
    drive(2'd0, COND_AL, 2'b11, 4'b1111, 1'b1, 1'b0);
    step();
    drive(2'd0, COND_AL, 2'b00, 4'h0, 1'b0, 1'b0);
    checks++;
    if (flags_o !== 4'b1111) begin
      errors++;
      $display("FAIL save_write got %b want 1111", flags_o);
    end
    drive(2'd0, COND_AL, 2'b11, 4'b0000, 1'b0, 1'b1);
    step();
    drive(2'd0, COND_AL, 2'b00, 4'h0, 1'b0, 1'b0);
    checks++;
    if (flags_o !== 4'b0110) begin
      errors++;
      $display("FAIL restore_wins got %b want 0110", flags_o);
    end
    idle();
  endtask

  task automatic test_swap_oor();
    drive(2'd0, COND_AL, 2'b11, 4'b0001, 1'b0, 1'b0);
    step();
    drive(2'd0, COND_AL, 2'b00, 4'h0, 1'b1, 1'b0);
    step();
    drive(2'd0, COND_AL, 2'b11, 4'b1000, 1'b0, 1'b0);
    step();
    drive(2'd0, COND_AL, 2'b00, 4'h0, 1'b1, 1'b1);
    checks++;
    if (flags_o !== 4'b1000) begin
      errors++;
      $display("FAIL swap_pre got %b want 1000", flags_o);
    end
    step();
    drive(2'd0, COND_AL, 2'b00, 4'h0, 1'b0, 1'b0);
    checks++;
    if (flags_o !== 4'b0001) begin
      errors++;
      $display("FAIL swap_live got %b want 0001", flags_o);
    end
    drive(2'd0, COND_AL, 2'b00, 4'h0, 1'b0, 1'b1);
    step();
    drive(2'd0, COND_AL, 2'b00, 4'h0, 1'b0, 1'b0);
    checks++;
    if (flags_o !== 4'b1000) begin
      errors++;
      $display("FAIL swap_shadow got %b want 1000", flags_o);
    end
    drive(2'd2, COND_AL, 2'b11, 4'b1111, 1'b1, 1'b1);
    checks++;
    if (cond_ex_o !== 1'b0) begin
      errors++;
      $display("FAIL oor_ex got %b want 0", cond_ex_o);
    end
    checks++;
    if (flags_o !== 4'b0000) begin
      errors++;
      $display("FAIL oor_flags got %b want 0000", flags_o);
    end
    step();
    drive(2'd0, COND_AL, 2'b00, 4'h0, 1'b0, 1'b0);
    checks++;
    if (flags_o !== 4'b1000) begin
      errors++;
      $display("FAIL oor_ctx0 got %b want 1000", flags_o);
    end
    drive(2'd1, COND_AL, 2'b00, 4'h0, 1'b0, 1'b0);
    checks++;
    if (flags_o !== 4'b1010) begin
      errors++;
      $display("FAIL oor_ctx1 got %b want 1010", flags_o);
    end
    drive(2'd0, COND_AL, 2'b00, 4'h0, 1'b0, 1'b0);
    checks++;
    if (flags_o !== 4'b1000) begin
      errors++;
      $display("FAIL shadow_kept got %b want 1000", flags_o);
    end
    idle();
  endtask

  task automatic test_mid_reset();
    reset = 1'b1;
    drive(2'd1, COND_AL, 2'b11, 4'b1111, 1'b1, 1'b0);
    step();
    reset = 1'b0;
    drive(2'd1, COND_AL, 2'b00, 4'h0, 1'b0, 1'b0);
    checks++;
    if (flags_o !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_ctx1 got %b want 0000", flags_o);
    end
    drive(2'd0, COND_AL, 2'b00, 4'h0, 1'b0, 1'b0);
    checks++;
    if (flags_o !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_ctx0 got %b want 0000", flags_o);
    end
    // shadow also cleared: restore yields zero
    drive(2'd0, COND_AL, 2'b00, 4'h0, 1'b0, 1'b1);
    step();
    drive(2'd0, COND_EQ, 2'b00, 4'h0, 1'b0, 1'b0);
    checks++;
    if (flags_o !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_shadow got %b want 0000", flags_o);
    end
    idle();
  endtask

`ifdef COND_STATS_EN
  task automatic test_stats();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (exec_cnt_o !== 4'd0 || squash_cnt_o !== 4'd0) begin
      errors++;
      $display("FAIL stats_rst got %0d/%0d want 0/0", exec_cnt_o, squash_cnt_o);
    end
    for (int i = 0; i < 20; i++) begin
      drive(2'd0, COND_AL, 2'b00, 4'h0, 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(2'd0, COND_EQ, 2'b00, 4'h0, 1'b0, 1'b0);
      step();
    end
    idle();
    #1;
    checks++;
    if (exec_cnt_o !== 4'd15) begin
      errors++;
      $display("FAIL exec_sat got %0d want 15", exec_cnt_o);
    end
    checks++;
    if (squash_cnt_o !== 4'd3) begin
      errors++;
      $display("FAIL squash_cnt got %0d want 3", squash_cnt_o);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (exec_cnt_o !== 4'd0 || squash_cnt_o !== 4'd0) begin
      errors++;
      $display("FAIL stats_clr got %0d/%0d want 0/0", exec_cnt_o, squash_cnt_o);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_write_eval();
    test_squash();
    test_save_restore();
    test_swap_oor();
    test_mid_reset();
`ifdef COND_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
